// File: rtl/sevenseg_capture_if.sv
`default_nettype none
// ============================================================================
// Module  : sevenseg_capture_if
// Brief   : Valid/ready frame stream carrying decoded display digits.
// Rev     : 1.0  initial release
// ============================================================================
interface sevenseg_capture_if #(
    parameter int NDIG = 4
);
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   dots;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output value,
        output dots,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  value,
        input  dots,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module  : sevenseg_capture
// Brief   : Samples a multiplexed 7-segment bus, debounces each digit strobe,
//           decodes patterns to nibbles and publishes complete frames.
// Rev     : 1.0  initial release
// ============================================================================
module sevenseg_capture #(
    parameter int NDIG   = 4,
    parameter int SETTLE = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic [7:0]      seg_in,
    input  wire logic [NDIG-1:0] dig_in,
    sevenseg_capture_if.master   frame,
    output logic                 bad_digit,
    output logic                 overrun,
    input  wire logic            clr_err
);
    localparam int              c_cnt_w = $clog2(SETTLE);
    localparam logic [c_cnt_w-1:0] c_cnt_top = c_cnt_w'(SETTLE - 1);
    localparam int              c_smp_w = NDIG + 8;

    logic [7:0]         r_seg_m, r_seg_s;
    logic [NDIG-1:0]    r_dig_m, r_dig_s;
    logic [c_smp_w-1:0] r_prev;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_armed;
    logic [NDIG-1:0]    r_seen;
    logic               r_bad;
    logic [4*NDIG-1:0]  r_stg_val;
    logic [NDIG-1:0]    r_stg_dot;
    logic [4*NDIG-1:0]  r_value;
    logic [NDIG-1:0]    r_dots;
    logic               r_valid;

    logic [c_smp_w-1:0] w_sample;
    logic               w_same;
    logic               w_accept;
    logic               w_onehot;
    logic               w_take;
    logic [4:0]         w_dec;
    logic               w_known;
    logic [3:0]         w_nib;
    logic [NDIG-1:0]    w_seen_nxt;
    logic               w_bad_nxt;
    logic               w_complete;
    logic               w_publish;
    logic [4*NDIG-1:0]  w_stg_val;
    logic [NDIG-1:0]    w_stg_dot;

    // Returns {recognised, nibble}; B shares 0x1F with 6, so it never appears.
    function automatic logic [4:0] f_decode(input logic [6:0] p);
        case (p)
            7'h7E:   return {1'b1, 4'h0};
            7'h30:   return {1'b1, 4'h1};
            7'h6D:   return {1'b1, 4'h2};
            7'h79:   return {1'b1, 4'h3};
            7'h33:   return {1'b1, 4'h4};
            7'h5B:   return {1'b1, 4'h5};
            7'h1F:   return {1'b1, 4'h6};
            7'h5F:   return {1'b1, 4'h6};
            7'h70:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h73:   return {1'b1, 4'h9};
            7'h7D:   return {1'b1, 4'hA};
            7'h0D:   return {1'b1, 4'hC};
            7'h3D:   return {1'b1, 4'hD};
            7'h4D:   return {1'b1, 4'hE};
            7'h45:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    assign w_sample   = {r_dig_s, r_seg_s};
    assign w_same     = (w_sample == r_prev);
    assign w_accept   = w_same && r_armed && (r_cnt == c_cnt_top);
    assign w_onehot   = (r_dig_s != '0) && ((r_dig_s & (r_dig_s - NDIG'(1))) == '0);
    assign w_take     = w_accept && w_onehot;
    assign w_dec      = f_decode(r_seg_s[7:1]);
    assign w_known    = w_dec[4];
    assign w_nib      = w_dec[3:0];
    assign w_seen_nxt = r_seen | (w_take ? r_dig_s : '0);
    assign w_bad_nxt  = r_bad | (w_take && !w_known);
    assign w_complete = w_take && (&w_seen_nxt);
    assign w_publish  = w_complete && !w_bad_nxt;

    // Staging merged with the slot being accepted, so completion can publish
    // on the same edge that writes the final digit.
    generate
        for (genvar i = 0; i < NDIG; i++) begin : g_slot
            assign w_stg_val[4*i +: 4] = (w_take && r_dig_s[i]) ? (w_known ? w_nib : 4'h0)
                                                                 : r_stg_val[4*i +: 4];
            assign w_stg_dot[i]        = (w_take && r_dig_s[i]) ? r_seg_s[0] : r_stg_dot[i];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_m <= '0;
            r_seg_s <= '0;
            r_dig_m <= '0;
            r_dig_s <= '0;
            r_prev  <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_seg_m <= seg_in;
            r_seg_s <= r_seg_m;
            r_dig_m <= dig_in;
            r_dig_s <= r_dig_m;
            r_prev  <= w_sample;
            if (!w_same) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end else begin
                if (r_cnt != c_cnt_top)
                    r_cnt <= r_cnt + c_cnt_w'(1);
                if (w_accept)
                    r_armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen    <= '0;
            r_bad     <= 1'b0;
            r_stg_val <= '0;
            r_stg_dot <= '0;
            r_value   <= '0;
            r_dots    <= '0;
            r_valid   <= 1'b0;
            bad_digit <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_stg_val <= w_stg_val;
            r_stg_dot <= w_stg_dot;
            if (w_complete) begin
                r_seen <= '0;
                r_bad  <= 1'b0;
            end else begin
                r_seen <= w_seen_nxt;
                r_bad  <= w_bad_nxt;
            end

            if (w_publish) begin
                r_value <= w_stg_val;
                r_dots  <= w_stg_dot;
                r_valid <= 1'b1;
            end else if (r_valid && frame.out_ready) begin
                r_valid <= 1'b0;
            end

            if (w_take && !w_known)
                bad_digit <= 1'b1;
            else if (clr_err)
                bad_digit <= 1'b0;

            if (w_publish && r_valid && !frame.out_ready)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
        end
    end

    assign frame.value     = r_value;
    assign frame.dots      = r_dots;
    assign frame.out_valid = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_sevenseg_capture
// Brief   : Directed scoreboard bench for sevenseg_capture.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sevenseg_capture;
    localparam int NDIG   = 4;
    localparam int SETTLE = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] seg_in = '0;
    logic [3:0] dig_in = '0;
    logic [7:0] seg2 = '0;
    logic [3:0] dig2 = '0;
    logic       clr_err = 1'b0;
    logic       bad_digit, overrun, bad2, ovr2;

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;
    logic [19:0] exp_q[$];

    sevenseg_capture_if #(.NDIG(NDIG)) frm ();
    sevenseg_capture_if #(.NDIG(NDIG)) frm2 ();

    sevenseg_capture #(.NDIG(NDIG), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .dig_in    (dig_in),
        .frame     (frm),
        .bad_digit (bad_digit),
        .overrun   (overrun),
        .clr_err   (clr_err)
    );

    sevenseg_capture #(.NDIG(NDIG), .SETTLE(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg2),
        .dig_in    (dig2),
        .frame     (frm2),
        .bad_digit (bad2),
        .overrun   (ovr2),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frames leave the DUT on edges where valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && frm.out_valid && frm.out_ready) begin
            n_xfer++;
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL spurious_frame: observed value 0x%0h with no frame expected", frm.value);
            end
            if (exp_q.size() != 0)
                check("frame_data", {12'h0, frm.dots, frm.value}, {12'h0, exp_q.pop_front()});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] d, input logic [7:0] s, input int hold);
        dig_in = d;
        seg_in = s;
        step(hold);
    endtask

    task automatic drive2(input logic [3:0] d, input logic [7:0] s, input int hold);
        dig2 = d;
        seg2 = s;
        step(hold);
    endtask

    task automatic send_frame(input logic [7:0] s0, s1, s2, s3);
        drive(4'b0001, s0, 40);
        drive(4'b0010, s1, 40);
        drive(4'b0100, s2, 40);
        drive(4'b1000, s3, 40);
    endtask

    initial begin
        frm.out_ready  = 1'b0;
        frm2.out_ready = 1'b0;

        // Reset with arbitrary pins: outputs clear without a clock edge
        #2;
        seg_in = 8'($urandom);
        dig_in = 4'($urandom);
        rst    = 1'b1;
        #1;
        check("reset_outputs", {7'h0, frm.out_valid, bad_digit, overrun, frm.dots, frm.value},
              32'h0);
        step(5);
        seg_in = '0;
        dig_in = '0;
        rst    = 1'b0;
        step(50);
        check("idle_no_valid", {31'h0, frm.out_valid}, 32'h0);

        // Clean frame with dp on digit 2, and exact completion latency
        frm.out_ready = 1'b1;
        exp_q.push_back({4'b0100, 16'h4321});
        drive(4'b0001, 8'h60, 40);
        drive(4'b0010, 8'hDA, 40);
        drive(4'b0100, 8'hF3, 40);
        drive(4'b1000, 8'h66, SETTLE + 2);
        check("latency_early", {31'h0, frm.out_valid}, 32'h0);
        step(1);
        check("latency_rise", {31'h0, frm.out_valid}, 32'h1);
        check("clean_value", {16'h0, frm.value}, 32'h4321);
        check("clean_dots", {28'h0, frm.dots}, 32'h4);
        step(40);
        check("clean_one_pulse", n_xfer, 1);
        check("clean_no_bad", {31'h0, bad_digit}, 32'h0);

        // Short flashes below the settle window are never accepted
        exp_q.push_back({4'b0000, 16'h4321});
        drive(4'b0001, 8'h60, 40);
        drive(4'b0001, 8'hFE, SETTLE - 2);
        drive(4'b0001, 8'h60, 40);
        drive(4'b0010, 8'hDA, 40);
        drive(4'b0100, 8'hF2, 40);
        drive(4'b1000, 8'h66, SETTLE - 2);
        drive(4'b0100, 8'hF2, 40);
        check("glitch_no_complete", n_xfer, 1);
        drive(4'b1000, 8'h66, 40);
        check("glitch_frame_out", n_xfer, 2);

        // SETTLE=2 instance: one-cycle flash rejected, real digit accepted
        drive2(4'b0001, 8'h60, 10);
        drive2(4'b0010, 8'hDA, 10);
        drive2(4'b0100, 8'hF2, 10);
        drive2(4'b1000, 8'h66, 1);
        drive2(4'b0100, 8'hF2, 10);
        check("s2_flash_rejected", {31'h0, frm2.out_valid}, 32'h0);
        drive2(4'b1000, 8'h66, 10);
        check("s2_valid", {31'h0, frm2.out_valid}, 32'h1);
        check("s2_value", {16'h0, frm2.value}, 32'h4321);

        // 0x3E decodes as 6; a g-only pattern poisons its frame
        exp_q.push_back({4'b0000, 16'h4326});
        send_frame(8'h3E, 8'hDA, 8'hF2, 8'h66);
        check("six_alt_out", n_xfer, 3);
        send_frame(8'h60, 8'h02, 8'hF2, 8'h66);
        check("bad_frame_dropped", n_xfer, 3);
        check("bad_digit_set", {31'h0, bad_digit}, 32'h1);
        exp_q.push_back({4'b0000, 16'h4321});
        send_frame(8'h60, 8'hDA, 8'hF2, 8'h66);
        check("after_bad_out", n_xfer, 4);
        check("bad_digit_sticky", {31'h0, bad_digit}, 32'h1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("bad_digit_cleared", {31'h0, bad_digit}, 32'h0);

        // Two frames with no consumer: second overwrites first
        frm.out_ready = 1'b0;
        send_frame(8'h60, 8'hDA, 8'hF2, 8'h66);
        check("ovr_first_value", {16'h0, frm.value}, 32'h4321);
        check("ovr_not_yet", {31'h0, overrun}, 32'h0);
        send_frame(8'hE0, 8'hE6, 8'hFB, 8'h1A);
        exp_q.push_back({4'b0100, 16'hCA97});
        check("ovr_second_value", {16'h0, frm.value}, 32'hCA97);
        check("ovr_second_dots", {28'h0, frm.dots}, 32'h4);
        check("ovr_set", {31'h0, overrun}, 32'h1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("ovr_cleared", {31'h0, overrun}, 32'h0);
        check("ovr_valid_held", {31'h0, frm.out_valid}, 32'h1);

        // Consumer takes the old frame on the very edge a new one completes
        drive(4'b0001, 8'h7A, 40);
        drive(4'b0010, 8'h9A, 40);
        drive(4'b0100, 8'h8A, 40);
        drive(4'b1000, 8'hFC, SETTLE + 2);
        frm.out_ready = 1'b1;
        step(1);
        frm.out_ready = 1'b0;
        exp_q.push_back({4'b0000, 16'h0FED});
        check("simul_valid", {31'h0, frm.out_valid}, 32'h1);
        check("simul_value", {16'h0, frm.value}, 32'h0FED);
        check("simul_no_ovr", {31'h0, overrun}, 32'h0);
        check("simul_xfer", n_xfer, 5);
        frm.out_ready = 1'b1;
        step(3);
        check("simul_drain", n_xfer, 6);
        check("simul_drained_valid", {31'h0, frm.out_valid}, 32'h0);

        // Blanked and multi-hot strobes are ignored
        drive(4'b0001, 8'h60, 40);
        drive(4'b0010, 8'hDA, 40);
        drive(4'b0100, 8'hF2, 40);
        drive(4'b0000, 8'h66, 100);
        drive(4'b0011, 8'h66, 100);
        drive(4'b1100, 8'h66, 100);
        check("blank_no_out", n_xfer, 6);
        exp_q.push_back({4'b0000, 16'h4321});
        drive(4'b1000, 8'h66, 40);
        check("blank_then_out", n_xfer, 7);

        // Reset mid-frame discards the digits already seen
        drive(4'b0001, 8'h60, 40);
        drive(4'b0010, 8'hDA, 40);
        rst    = 1'b1;
        dig_in = '0;
        #1;
        check("midrst_outputs", {30'h0, frm.out_valid, bad_digit}, 32'h0);
        step(3);
        rst = 1'b0;
        step(10);
        drive(4'b0100, 8'hFA, 40);
        drive(4'b1000, 8'h1A, 40);
        check("midrst_no_complete", n_xfer, 7);
        exp_q.push_back({4'b0000, 16'hCA97});
        drive(4'b0001, 8'hE0, 40);
        drive(4'b0010, 8'hE6, 40);
        check("midrst_out", n_xfer, 8);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
